// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// parameter defaults and parity-type constants.
package uart_tx_arbiter_pkg;

    localparam int NREQ_DEF         = 4;
    localparam int BUSY_TIMEOUT_DEF = 3;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request after last_owner,
// wrapping around, so the previous owner has lowest priority.
module uart_rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        // NOTE: every variable gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        winner    = last_owner;
        any_valid = |req;
        found     = 1'b0;
        idx       = last_owner;
        for (int k = 1; k <= NREQ; k++) begin
            // NREQ is a power of two, so the index wraps by truncation.
            idx = last_owner + IDX_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer among NREQ requesters: round-robin grant,
// registered launch of byte/parity config, busy-handshake with timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ         = NREQ_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_par_en,
    input  logic [NREQ-1:0]   req_par_typ,
    input  logic              tx_busy,
    output logic [7:0]        p_data,
    output logic              par_en,
    output logic              par_typ,
    output logic              data_valid,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]       p_data_q, p_data_d;
    logic             par_en_q, par_en_d;
    logic             par_typ_q, par_typ_d;
    logic             data_valid_q, data_valid_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] winner;
    logic             any_valid;

    uart_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        p_data_d     = p_data_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        data_valid_d = 1'b0;
        gnt_d        = '0;
        done_d       = '0;
        err_d        = 1'b0;
        cnt_inc      = cnt_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (en && any_valid) begin
                    state_d        = S_LAUNCH;
                    owner_d        = winner;
                    last_owner_d   = winner;
                    p_data_d       = req_data[{winner, 3'b000} +: 8];
                    par_en_d       = req_par_en[winner];
                    par_typ_d      = req_par_typ[winner];
                    gnt_d[winner]  = 1'b1;
                    data_valid_d   = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
                cnt_d   = '0;
            end
            S_WAIT_BUSY: begin
                // A busy seen on the last allowed cycle still counts as a start.
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
                        done_d[owner_q] = 1'b1;
                        err_d           = 1'b1;
                        state_d         = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every flop updates from the
    // values present before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NREQ - 1);
            cnt_q        <= '0;
            p_data_q     <= 8'h00;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            data_valid_q <= 1'b0;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            p_data_q     <= p_data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            data_valid_q <= data_valid_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign p_data     = p_data_q;
    assign par_en     = par_en_q;
    assign par_typ    = par_typ_q;
    assign data_valid = data_valid_q;
    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: frame-level reference model with
// a behavioural serializer, directed scenarios followed by random traffic.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int BT   = 3;
    localparam int HOLD = 11;   // cycles the serializer keeps tx_busy high

    logic           clk         = 1'b0;
    logic           rst         = 1'b0;
    logic           en          = 1'b0;
    logic [N-1:0]   req         = '0;
    logic [8*N-1:0] req_data    = '0;
    logic [N-1:0]   req_par_en  = '0;
    logic [N-1:0]   req_par_typ = '0;
    logic           tx_busy     = 1'b0;
    logic [7:0]     p_data;
    logic           par_en, par_typ, data_valid, err;
    logic [N-1:0]   gnt, done;

    uart_tx_arbiter #(.NREQ(N), .BUSY_TIMEOUT(BT)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .req_data    (req_data),
        .req_par_en  (req_par_en),
        .req_par_typ (req_par_typ),
        .tx_busy     (tx_busy),
        .p_data      (p_data),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .data_valid  (data_valid),
        .gnt         (gnt),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Frame-level model: round-robin pointer plus the one frame in flight,
    // with its completion cycle computed from the serializer's behaviour.
    int         m_last  = N - 1;
    bit         m_busy  = 1'b0;
    int         m_owner = 0;
    int         m_done  = 0;
    int         m_free  = 1 << 30;
    bit         m_err   = 1'b0;
    logic [7:0] m_byte  = '0;
    logic       m_pe    = 1'b0;
    logic       m_pt    = 1'b0;

    int  force_j  = -1;   // serializer start delay; 0 = never raises busy
    int  cur_j    = 0;
    int  ser_rise = -1;
    int  ser_fall = -1;
    bit  keep_all = 1'b0;
    bit  post_ff  = 1'b0;
    int  obs_log[$];
    int  rr_exp[5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int k, input logic [7:0] b, input logic pe, input logic pt);
        req_data[8*k +: 8] = b;
        req_par_en[k]      = pe;
        req_par_typ[k]     = pt;
        req[k]             = 1'b1;
    endtask

    task automatic step(input bit rnd);
        logic [N-1:0] eg, ed;
        logic         edv, eerr;
        int           w;
        @(negedge clk);
        cyc++;
        eg = '0; ed = '0; edv = 1'b0; eerr = 1'b0;
        if (rst) begin
            if (m_busy && cyc == m_done) begin
                ed     = N'(1) << m_owner;
                eerr   = m_err;
                m_busy = 1'b0;
                m_free = cyc + 1;
            end else if (!m_busy && cyc >= m_free && en && req != '0) begin
                w       = rr_pick(req, m_last);
                eg      = N'(1) << w;
                edv     = 1'b1;
                m_last  = w;
                m_owner = w;
                m_byte  = req_data[8*w +: 8];
                m_pe    = req_par_en[w];
                m_pt    = req_par_typ[w];
                cur_j   = (force_j >= 0) ? force_j : $urandom_range(0, 3);
                m_err   = (cur_j == 0);
                m_done  = m_err ? cyc + 1 + BT : cyc + cur_j + HOLD + 1;
                m_busy  = 1'b1;
            end
        end else begin
            check("p_data_in_reset", p_data, 0);
        end
        check("gnt", gnt, eg);
        check("data_valid", data_valid, edv);
        check("done", done, ed);
        check("err", err, eerr);
        if (m_busy || ed != '0) begin
            check("p_data", p_data, m_byte);
            check("par_en", par_en, m_pe);
            check("par_typ", par_typ, m_pt);
        end
        for (int k = 0; k < N; k++)
            if (gnt[k] === 1'b1) obs_log.push_back(k);

        if (rst) begin
            if (data_valid === 1'b1 && cur_j > 0) begin
                ser_rise = cyc + cur_j;
                ser_fall = ser_rise + HOLD;
            end
            if (cyc == ser_rise) tx_busy = 1'b1;
            if (cyc == ser_fall) tx_busy = 1'b0;
        end

        for (int k = 0; k < N; k++) begin
            if (gnt[k] === 1'b1) begin
                req[k]             = 1'b0;
                req_data[8*k +: 8] = post_ff ? 8'hFF : 8'($urandom);
                req_par_en[k]      = 1'($urandom);
                req_par_typ[k]     = 1'($urandom);
            end else if (!req[k] && (keep_all || (rnd && $urandom_range(0, 3) == 0))) begin
                set_req(k, 8'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        if (rnd) en = ($urandom_range(0, 7) != 0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_p_data", p_data, 0);
        check("rst_par_en", par_en, 0);
        check("rst_par_typ", par_typ, 0);
        m_busy   = 1'b0;
        m_last   = N - 1;
        m_free   = 1 << 30;
        tx_busy  = 1'b0;
        ser_rise = -1;
        ser_fall = -1;
        req      = '0;
    endtask

    task automatic release_rst();
        rst    = 1'b1;
        m_last = N - 1;
        m_free = cyc + 1;
    endtask

    initial begin
        int dv_wait;

        repeat (2) step(1'b0);
        release_rst();
        en = 1'b1;

        // all four requesting continuously: 0,1,2,3,0
        keep_all = 1'b1;
        obs_log.delete();
        for (int i = 0; i < 400 && obs_log.size() < 5; i++) step(1'b0);
        keep_all = 1'b0;
        req      = '0;
        check("rr_count", obs_log.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("rr_order%0d", i), (i < obs_log.size()) ? obs_log[i] : -1, rr_exp[i]);
        repeat (20) step(1'b0);

        // single requester, busy one cycle after launch
        force_j = 1;
        set_req(0, 8'hA5, 1'b1, PAR_EVEN);
        repeat (20) step(1'b0);

        // en low blocks the grant; dropping en mid-frame does not abort
        force_j = 2;
        en = 1'b0;
        set_req(2, 8'h5A, 1'b0, PAR_ODD);
        repeat (5) step(1'b0);
        en = 1'b1;
        repeat (4) step(1'b0);
        en = 1'b0;
        repeat (20) step(1'b0);
        en = 1'b1;

        // source data changes right after grant
        force_j = 3;
        post_ff = 1'b1;
        set_req(1, 8'h3C, 1'b1, PAR_ODD);
        repeat (20) step(1'b0);
        post_ff = 1'b0;

        // serializer never answers: timeout, then the next requester
        force_j = 0;
        set_req(1, 8'h11, 1'b0, PAR_EVEN);
        set_req(2, 8'h22, 1'b1, PAR_ODD);
        repeat (16) step(1'b0);

        // reset while waiting for the frame to end
        force_j = 1;
        set_req(3, 8'h77, 1'b1, PAR_EVEN);
        dv_wait = 0;
        while (data_valid !== 1'b1 && dv_wait < 20) begin
            step(1'b0);
            dv_wait++;
        end
        check("launch_seen", data_valid, 1);
        repeat (4) step(1'b0);
        apply_reset();
        repeat (2) step(1'b0);
        set_req(0, 8'h01, 1'b0, PAR_EVEN);
        set_req(1, 8'h02, 1'b0, PAR_EVEN);
        release_rst();
        obs_log.delete();
        repeat (30) step(1'b0);
        check("post_rst_first", (obs_log.size() > 0) ? obs_log[0] : -1, 0);

        // random traffic, random en, random serializer latency and timeouts
        force_j = -1;
        repeat (3000) step(1'b1);
        en = 1'b1;
        repeat (100) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
